// File: rtl/ahb_mtx_arb_rr_burst.sv
// Round-robin arbiter for one shared AHB slave port; holds the grant across
// fixed/undefined-length bursts and locked sequences.
module ahb_mtx_arb_rr_burst #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [2:0]           addr_in_port,
  output logic                 no_port,
  output logic                 burst_active
);

  localparam int unsigned IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'b001;

  logic [2:0]       addr_q, addr_d;
  logic             no_port_q, no_port_d;
  logic             burst_q, burst_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] load_c;
  logic             incr_hold_c;
  logic             burst_hold_c;
  logic             found_c;

  // Remaining-beat load value for a NONSEQ, indexed by burst length class
  always_comb begin
    load_c = '0;
    case (HBURSTM[2:1])
      2'b01:   load_c = CNT_W'(3);
      2'b10:   load_c = CNT_W'(7);
      2'b11:   load_c = CNT_W'(15);
      default: load_c = '0;
    endcase
  end

  always_comb begin
    int unsigned start;
    int unsigned idx;
    addr_d       = addr_q;
    no_port_d    = no_port_q;
    burst_d      = burst_q;
    beats_d      = beats_q;
    incr_hold_c  = 1'b0;
    burst_hold_c = 1'b0;
    found_c      = 1'b0;
    start        = 32'(addr_q) + (no_port_q ? 32'd0 : 32'd1);
    idx          = 0;
    if (HREADYM) begin
      if (HTRANSM == TR_IDLE) begin
        beats_d = '0;
      end else if (HSELM && HTRANSM == TR_NONSEQ) begin
        beats_d = load_c;
      end else if (HSELM && HTRANSM == TR_SEQ && beats_q != '0) begin
        beats_d = beats_q - CNT_W'(1);
      end
      incr_hold_c  = (HBURSTM == BURST_INCR) && (HTRANSM != TR_IDLE) && HSELM;
      burst_hold_c = (beats_d != '0) || incr_hold_c;
      if (HMASTLOCKM || burst_hold_c) begin
        no_port_d = 1'b0;
        burst_d   = burst_hold_c;
      end else begin
        burst_d = 1'b0;
        // Start past the current owner; with no owner the pointer port goes first
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
          idx = (start + k) % NUM_PORTS;
          if (!found_c && req_port[IDX_W'(idx)]) begin
            found_c = 1'b1;
            addr_d  = 3'(idx);
          end
        end
        no_port_d = !(found_c || HSELM);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q    <= '0;
      no_port_q <= 1'b1;
      burst_q   <= 1'b0;
      beats_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      no_port_q <= no_port_d;
      burst_q   <= burst_d;
      beats_q   <= beats_d;
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;
  assign burst_active = burst_q;

endmodule

// File: tb/tb_ahb_mtx_arb_rr_burst.sv
// Directed plus randomized check of the burst-aware round-robin arbiter
// against a transaction-level reference model.
module tb_ahb_mtx_arb_rr_burst;

  localparam int N = 4;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [N-1:0] req_port;
  logic         HREADYM;
  logic         HSELM;
  logic [1:0]   HTRANSM;
  logic [2:0]   HBURSTM;
  logic         HMASTLOCKM;
  logic [2:0]   addr_in_port;
  logic         no_port;
  logic         burst_active;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_addr, m_nop, m_burst, m_beats;

  ahb_mtx_arb_rr_burst #(.NUM_PORTS(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_in_port), .no_port(no_port), .burst_active(burst_active)
  );

  always #5 HCLK = ~HCLK;

  function automatic int burst_len(input int hb);
    case (hb)
      2, 3:    return 4;
      4, 5:    return 8;
      6, 7:    return 16;
      default: return 1;
    endcase
  endfunction

  // One edge of the arbiter expressed from the rules, in plain integers
  task automatic model(input int rst, input int req, input int rdy, input int sel,
                       input int tr, input int hb, input int lk);
    int nb, incr, hold, first;
    if (rst == 0) begin
      m_addr = 0; m_nop = 1; m_burst = 0; m_beats = 0;
      return;
    end
    if (rdy == 0) return;
    nb = m_beats;
    if (tr == 0) nb = 0;
    else if (sel == 1 && tr == 2) nb = burst_len(hb) - 1;
    else if (sel == 1 && tr == 3 && nb > 0) nb = nb - 1;
    m_beats = nb;
    incr = (hb == 1 && tr != 0 && sel == 1) ? 1 : 0;
    hold = (lk == 1 || nb != 0 || incr == 1) ? 1 : 0;
    if (hold == 1) begin
      m_nop = 0;
      m_burst = (nb != 0 || incr == 1) ? 1 : 0;
    end else begin
      m_burst = 0;
      first = -1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_addr + (m_nop == 1 ? 0 : 1) + k) % N;
        if (first < 0 && ((req >> p) & 1) == 1) first = p;
      end
      if (first >= 0) begin
        m_addr = first; m_nop = 0;
      end else if (sel == 1) begin
        m_nop = 0;
      end else begin
        m_nop = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int rst, input int req, input int rdy, input int sel,
                      input int tr, input int hb, input int lk);
    @(negedge HCLK);
    HRESETn    = rst[0];
    req_port   = N'(req);
    HREADYM    = rdy[0];
    HSELM      = sel[0];
    HTRANSM    = 2'(tr);
    HBURSTM    = 3'(hb);
    HMASTLOCKM = lk[0];
    model(rst, req, rdy, sel, tr, hb, lk);
    @(posedge HCLK);
    #1;
    chk("addr_in_port", 8'(addr_in_port), 8'(m_addr));
    chk("no_port",      8'(no_port),      8'(m_nop));
    chk("burst_active", 8'(burst_active), 8'(m_burst));
  endtask

  initial begin
    int r_rst, r_req, r_rdy, r_sel, r_tr, r_hb, r_lk;
    m_addr = 0; m_nop = 1; m_burst = 0; m_beats = 0;

    // reset
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("reset_addr", 8'(addr_in_port), 8'd0);
    chk("reset_nop",  8'(no_port), 8'd1);

    // requests 0101 with no slave traffic
    step(1, 5, 1, 0, 0, 0, 0);
    chk("rr_first", 8'(addr_in_port), 8'd0);
    chk("rr_first_nop", 8'(no_port), 8'd0);
    step(1, 5, 1, 0, 0, 0, 0);
    chk("rr_seq0", 8'(addr_in_port), 8'd2);
    step(1, 5, 1, 0, 0, 0, 0);
    chk("rr_seq1", 8'(addr_in_port), 8'd0);
    step(1, 5, 1, 0, 0, 0, 0);
    chk("rr_seq2", 8'(addr_in_port), 8'd2);

    // move grant to port 1, then INCR4 under full contention
    step(1, 2, 1, 0, 0, 0, 0);
    step(1, 15, 1, 1, 2, 3, 0);
    chk("incr4_hold", 8'(burst_active), 8'd1);
    step(1, 15, 1, 1, 3, 3, 0);
    step(1, 15, 1, 1, 3, 3, 0);
    chk("incr4_still1", 8'(addr_in_port), 8'd1);
    step(1, 15, 1, 1, 3, 3, 0);
    chk("incr4_release", 8'(addr_in_port), 8'd2);
    chk("incr4_release_ba", 8'(burst_active), 8'd0);

    // INCR8 from port 2 with two wait states and a BUSY
    step(1, 15, 1, 1, 2, 5, 0);
    step(1, 15, 1, 1, 3, 5, 0);
    step(1, 15, 0, 1, 3, 5, 0);
    step(1, 15, 0, 1, 3, 5, 0);
    chk("incr8_wait", 8'(burst_active), 8'd1);
    step(1, 15, 1, 1, 1, 5, 0);
    for (int i = 0; i < 5; i++) step(1, 15, 1, 1, 3, 5, 0);
    chk("incr8_before_last", 8'(addr_in_port), 8'd2);
    step(1, 15, 1, 1, 3, 5, 0);
    chk("incr8_release", 8'(addr_in_port), 8'd3);

    // port 3 INCR4 terminated early by IDLE while port 0 requests
    step(1, 9, 1, 1, 2, 3, 0);
    step(1, 9, 1, 1, 3, 3, 0);
    step(1, 9, 1, 1, 0, 3, 0);
    chk("early_term_grant", 8'(addr_in_port), 8'd0);
    chk("early_term_ba", 8'(burst_active), 8'd0);

    // locked sequence on port 2
    step(1, 4, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 15, 1, 1, 2, 0, 1);
      chk("lock_hold", 8'(addr_in_port), 8'd2);
    end
    step(1, 15, 1, 1, 0, 0, 0);
    chk("lock_rotate", 8'(addr_in_port), 8'd3);

    // reset in the middle of a WRAP16
    step(1, 15, 1, 1, 2, 6, 0);
    step(1, 15, 1, 1, 3, 6, 0);
    step(1, 15, 1, 1, 3, 6, 0);
    step(0, 15, 0, 1, 3, 6, 0);
    chk("wrap16_rst_addr", 8'(addr_in_port), 8'd0);
    chk("wrap16_rst_nop", 8'(no_port), 8'd1);
    chk("wrap16_rst_ba", 8'(burst_active), 8'd0);
    step(1, 0, 1, 0, 0, 6, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 49) == 0) ? 0 : 1;
      r_req = int'($urandom_range(0, (1 << N) - 1));
      r_rdy = ($urandom_range(0, 4) == 0) ? 0 : 1;
      r_sel = int'($urandom_range(0, 3) != 0);
      r_tr  = int'($urandom_range(0, 3));
      r_hb  = int'($urandom_range(0, 7));
      r_lk  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      step(r_rst, r_req, r_rdy, r_sel, r_tr, r_hb, r_lk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
